// File: rtl/hwag.sv
// rtl/hwag.sv - hardware angle generator register file (64 x 16-bit SSRAM image)
//
// Storage and bus interface only. The words are exposed as ssram_out[0..DEPTH-1]
// for the angle-generation logic downstream.
//
// Ports:
//   clk         in     system clock, all state changes on rising edge
//   rst         in     asynchronous active-low reset
//   ssram_we    in     write strobe, active high, level-sampled on clk
//   ssram_re    in     read enable, active high
//   ssram_addr  in     word address (ADDR_W bits, full-width range compare)
//   ssram_data  inout  shared data bus; driven only while reading out

module hwag #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssram_we,
  input  logic              ssram_re,
  input  logic [ADDR_W-1:0] ssram_addr,
  inout  wire  [DATA_W-1:0] ssram_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_CMP = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] ssram_out [0:DEPTH-1];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              drive_en;
  logic [DATA_W-1:0] rd_data;

  // Compare the whole address so that e.g. 64 never aliases onto word 0.
  assign in_range = ({1'b0, ssram_addr} < DEPTH_CMP);
  assign idx      = ssram_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ssram_out[i] <= '0;
      end
    end else if (ssram_we && in_range) begin
      ssram_out[idx] <= ssram_data;
    end
  end

  // Write wins over read, and rst gates the driver directly so the bus is
  // released the instant reset asserts.
  assign drive_en   = rst & ssram_re & ~ssram_we;
  assign rd_data    = in_range ? ssram_out[idx] : '0;
  assign ssram_data = drive_en ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_hwag.sv
// tb/tb_hwag.sv - directed self-checking bench for hwag

module tb_hwag;

  localparam logic [15:0] BUS_IDLE = 16'hFFFF;

  logic        clk;
  logic        rst;
  logic        ssram_we;
  logic        ssram_re;
  logic [7:0]  ssram_addr;
  wire  [15:0] ssram_data;
  logic        tb_en;
  logic [15:0] tb_val;

  int n_checks;
  int n_pass;

  // An undriven bus floats to all ones, so "high-Z" reads back as BUS_IDLE.
  pullup pu_bus [15:0] (ssram_data);
  assign ssram_data = tb_en ? tb_val : 16'bz;

  hwag dut (
    .clk        (clk),
    .rst        (rst),
    .ssram_we   (ssram_we),
    .ssram_re   (ssram_re),
    .ssram_addr (ssram_addr),
    .ssram_data (ssram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    ssram_we   = 1'b1;
    ssram_re   = 1'b0;
    ssram_addr = addr;
    tb_en      = 1'b1;
    tb_val     = data;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    ssram_we = 1'b0;
    ssram_re = 1'b0;
    tb_en    = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 64; i++) bus_write(i[7:0], 16'(2 * i));
    bus_idle();
  endtask

  task automatic check_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.ssram_out[i] !== 16'h0000) bad++;
    check(tag, 16'(bad), 16'd0);
  endtask

  initial begin
    int bad;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b0;
    ssram_we   = 1'b0;
    ssram_re   = 1'b0;
    ssram_addr = 8'd0;
    tb_en      = 1'b0;
    tb_val     = 16'h0;

    // 1 Reset, including an attempted write and read while held
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_words");
    check("reset_bus_z", ssram_data, BUS_IDLE);
    @(negedge clk);
    ssram_we = 1'b1; ssram_addr = 8'd3; tb_en = 1'b1; tb_val = 16'hAAAA;
    @(posedge clk); #1;
    check("reset_write_ignored", dut.ssram_out[3], 16'h0000);
    @(negedge clk);
    ssram_we = 1'b0; tb_en = 1'b0; ssram_re = 1'b1;
    #1;
    check("reset_read_z", ssram_data, BUS_IDLE);
    ssram_re = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("post_reset_words");

    // 2 Fill
    fill();
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.ssram_out[i] !== 16'(2 * i)) bad++;
    check("fill_words_bad", 16'(bad), 16'd0);
    check("fill_word63", dut.ssram_out[63], 16'd126);

    // 3 Readback sweep, zero-latency from address change
    @(negedge clk);
    ssram_re = 1'b1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      ssram_addr = i[7:0];
      #1;
      if (ssram_data !== 16'(2 * i)) bad++;
    end
    check("readback_bad", 16'(bad), 16'd0);
    ssram_addr = 8'd17;
    #1;
    check("readback_17", ssram_data, 16'd34);
    ssram_re = 1'b0;
    #1;
    check("re0_bus_z", ssram_data, BUS_IDLE);

    // Write then read in the very next cycle returns the new value
    bus_write(8'd7, 16'h5A5A);
    ssram_we = 1'b0; tb_en = 1'b0; ssram_re = 1'b1;
    #1;
    check("read_after_write", ssram_data, 16'h5A5A);
    bus_idle();

    // 4 Range
    bus_write(8'd64, 16'hBEEF);
    bus_write(8'd255, 16'hBEEF);
    bus_idle();
    check("oor_no_alias_w0", dut.ssram_out[0], 16'd0);
    check("oor_no_alias_w63", dut.ssram_out[63], 16'd126);
    ssram_re = 1'b1; ssram_addr = 8'd200;
    #1;
    check("oor_read_zero", ssram_data, 16'h0000);
    ssram_addr = 8'd64;
    #1;
    check("oor_read_64", ssram_data, 16'h0000);
    ssram_re = 1'b0;

    // 5 Collision: write wins, DUT stays off the bus
    @(negedge clk);
    ssram_we = 1'b1; ssram_re = 1'b1; ssram_addr = 8'd5;
    tb_en = 1'b1; tb_val = 16'h1234;
    #1;
    check("collision_bus", ssram_data, 16'h1234);
    @(posedge clk); #1;
    check("collision_word5", dut.ssram_out[5], 16'h1234);
    tb_en = 1'b0;
    #1;
    check("collision_no_drive", ssram_data, BUS_IDLE);
    bus_idle();

    // 6 Mid-operation reset
    fill();
    @(negedge clk);
    ssram_re = 1'b1; ssram_addr = 8'd10;
    #1;
    check("pre_reset_read", ssram_data, 16'd20);
    #1;
    rst = 1'b0;
    #1;
    check("midreset_bus_z", ssram_data, BUS_IDLE);
    check_all_zero("midreset_words");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("after_reset_read", ssram_data, 16'h0000);
    ssram_re = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("after_reset_words");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
